// File: rtl/flash_req_arbiter.sv
// flash_req_arbiter: round-robin arbiter that serializes two single-transfer requesters
// onto the SPI NOR flash controller's APB port, with a fixed-length access phase.
module flash_req_arbiter #(
  parameter int unsigned ACCESS_CYCLES = 40
) (
  input  logic        p_clk,
  input  logic        p_resetn,
  input  logic        rq0_valid,
  input  logic        rq0_write,
  input  logic [31:0] rq0_addr,
  input  logic [31:0] rq0_wdata,
  output logic        rq0_ready,
  output logic        rq0_done,
  output logic [31:0] rq0_rdata,
  input  logic        rq1_valid,
  input  logic        rq1_write,
  input  logic [31:0] rq1_addr,
  input  logic [31:0] rq1_wdata,
  output logic        rq1_ready,
  output logic        rq1_done,
  output logic [31:0] rq1_rdata,
  output logic        busy,
  output logic [31:0] p_addr,
  output logic        p_write,
  output logic [31:0] p_wdata,
  output logic        p_sel_x,
  output logic        p_enable,
  input  logic [31:0] p_rdata
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t state, state_n;
  logic [7:0] cnt;
  logic last, gnt, win, start, fin;
  logic [1:0] ready, done;
  logic [1:0][31:0] rdata;
  always_comb begin
    win = (rq0_valid && rq1_valid) ? ~last : rq1_valid;
    start = (state == IDLE) && (rq0_valid || rq1_valid);
    fin = (state == ACCESS) && (cnt == '0);
    state_n = state;
    case (state)
      IDLE:    state_n = start ? SETUP : IDLE;
      SETUP:   state_n = ACCESS;
      ACCESS:  state_n = fin ? RESP : ACCESS;
      default: state_n = IDLE;
    endcase
  end
  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge p_clk or negedge p_resetn) begin
    if (!p_resetn) begin
      state <= IDLE;
      cnt <= '0;
      last <= 1'b1;
      gnt <= 1'b0;
      ready <= '0;
      done <= '0;
      rdata <= '0;
      busy <= 1'b0;
      p_sel_x <= 1'b0;
      p_enable <= 1'b0;
      p_write <= 1'b0;
      p_addr <= '0;
      p_wdata <= '0;
    end else begin
      state <= state_n;
      busy <= state_n != IDLE;
      p_sel_x <= (state_n == SETUP) || (state_n == ACCESS);
      p_enable <= state_n == ACCESS;
      ready <= start ? (win ? 2'b10 : 2'b01) : 2'b00;
      done <= fin ? (gnt ? 2'b10 : 2'b01) : 2'b00;
      cnt <= (state == SETUP) ? 8'(ACCESS_CYCLES - 1) : (state == ACCESS && !fin) ? cnt - 8'd1 : cnt;
      if (start) begin
        gnt <= win;
        last <= win;
        p_write <= win ? rq1_write : rq0_write;
        p_addr <= win ? rq1_addr : rq0_addr;
        p_wdata <= win ? rq1_wdata : rq0_wdata;
      end
      // Command bus returns to zero for the response cycle; only reads update rdata.
      if (fin) begin
        p_write <= 1'b0;
        p_addr <= '0;
        p_wdata <= '0;
        if (!p_write) rdata[gnt] <= p_rdata;
      end
    end
  end
  assign rq0_ready = ready[0];
  assign rq1_ready = ready[1];
  assign rq0_done = done[0];
  assign rq1_done = done[1];
  assign rq0_rdata = rdata[0];
  assign rq1_rdata = rdata[1];
endmodule

// File: tb/tb_flash_req_arbiter.sv
// tb_flash_req_arbiter: randomized and directed scenarios checked against a
// transfer-timeline reference model of the arbiter.
module tb_flash_req_arbiter;
  localparam int AC = 4;
  logic p_clk = 1'b0;
  logic p_resetn = 1'b0;
  logic [1:0] v = '0;
  logic [1:0] wr = '0;
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [31:0] p_rdata = '0;
  logic rq0_ready, rq1_ready, rq0_done, rq1_done, busy, p_write, p_sel_x, p_enable;
  logic [31:0] rq0_rdata, rq1_rdata, p_addr, p_wdata;
  int checks = 0;
  int errors = 0;
  int want [2];
  bit rnd_cmd, wr_only, force_rd;
  logic [31:0] force_val;

  flash_req_arbiter #(.ACCESS_CYCLES(AC)) dut (
    .p_clk(p_clk), .p_resetn(p_resetn),
    .rq0_valid(v[0]), .rq0_write(wr[0]), .rq0_addr(addr[0]), .rq0_wdata(wdata[0]),
    .rq0_ready(rq0_ready), .rq0_done(rq0_done), .rq0_rdata(rq0_rdata),
    .rq1_valid(v[1]), .rq1_write(wr[1]), .rq1_addr(addr[1]), .rq1_wdata(wdata[1]),
    .rq1_ready(rq1_ready), .rq1_done(rq1_done), .rq1_rdata(rq1_rdata),
    .busy(busy), .p_addr(p_addr), .p_write(p_write), .p_wdata(p_wdata),
    .p_sel_x(p_sel_x), .p_enable(p_enable), .p_rdata(p_rdata)
  );

  always #5 p_clk = ~p_clk;

  // Reference model: a transfer is a timeline of AC+2 cycles starting at grant
  // (t=0 setup, 1..AC access, AC+1 response), followed by at least one idle cycle.
  int m_t;
  bit m_act, m_last, m_gnt, m_wr;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] m_rd [2];
  always @(posedge p_clk or negedge p_resetn) begin
    if (!p_resetn) begin
      m_act = 0; m_t = 0; m_last = 1; m_gnt = 0; m_wr = 0;
      m_addr = 0; m_wdata = 0; m_rd[0] = 0; m_rd[1] = 0;
    end else if (!m_act) begin
      if (v != 2'b00) begin
        m_gnt = (v == 2'b11) ? !m_last : v[1];
        m_last = m_gnt;
        m_wr = wr[m_gnt]; m_addr = addr[m_gnt]; m_wdata = wdata[m_gnt];
        m_act = 1; m_t = 0;
      end
    end else begin
      if (m_t == AC && !m_wr) m_rd[m_gnt] = p_rdata;
      m_t++;
      if (m_t == AC + 2) m_act = 0;
    end
  end

  function automatic logic [135:0] exp_vec();
    logic sel, en, d;
    sel = m_act && m_t <= AC;
    en = m_act && m_t >= 1 && m_t <= AC;
    d = m_act && m_t == AC + 1;
    return {m_act, sel, en, sel && m_wr, sel ? m_addr : 32'h0, sel ? m_wdata : 32'h0,
            m_act && m_t == 0 && !m_gnt, m_act && m_t == 0 && m_gnt, d && !m_gnt, d && m_gnt,
            m_rd[0], m_rd[1]};
  endfunction

  function automatic logic [135:0] dut_vec();
    return {busy, p_sel_x, p_enable, p_write, p_addr, p_wdata,
            rq0_ready, rq1_ready, rq0_done, rq1_done, rq0_rdata, rq1_rdata};
  endfunction

  task automatic advance();
    @(negedge p_clk);
  endtask

  task automatic new_cmd(input int i);
    wr[i] = wr_only ? 1'b1 : 1'($urandom_range(0, 1));
    addr[i] = $urandom();
    wdata[i] = $urandom();
  endtask

  // Requester behaviour: drop or renew valid after seeing ready; controller drives p_rdata.
  task automatic req_update();
    for (int i = 0; i < 2; i++) begin
      if ((i == 0) ? rq0_ready : rq1_ready) begin
        want[i]--;
        if (want[i] > 0 && rnd_cmd) new_cmd(i);
      end
      v[i] = want[i] > 0;
    end
    p_rdata = (force_rd && m_act && m_t == AC) ? force_val : $urandom();
  endtask

  task automatic test_reset();
    int first;
    p_resetn = 0;
    for (int k = 0; k < 5; k++) begin
      v = 2'($urandom()); wr = 2'($urandom());
      addr[0] = $urandom(); addr[1] = $urandom(); wdata[0] = $urandom(); wdata[1] = $urandom();
      p_rdata = $urandom();
      advance();
      checks++;
      if (dut_vec() !== 136'h0) begin
        errors++; $display("FAIL reset_outputs: got %h want 0", dut_vec());
      end
    end
    wr_only = 1; rnd_cmd = 1; force_rd = 0;
    want[0] = 1; want[1] = 1; new_cmd(0); new_cmd(1); v = 2'b11;
    p_resetn = 1;
    first = -1;
    for (int k = 0; k < 40 && (want[0] > 0 || want[1] > 0 || busy); k++) begin
      advance();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL reset_release k=%0d: got %h want %h", k, dut_vec(), exp_vec());
      end
      if (first < 0 && (rq0_ready || rq1_ready)) first = int'(rq1_ready);
      req_update();
    end
    checks++;
    if (first !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL first_grant: got %0d busy %b want 0 busy 0", first, busy);
    end
  endtask

  task automatic test_single_write();
    int sel_n, en_n, rdy_n, last_en, done_at, bad;
    bit rdy_ok;
    rnd_cmd = 0; force_rd = 0;
    wr[0] = 1; addr[0] = 32'h0; wdata[0] = 32'hFF00FF00;
    want[0] = 1; want[1] = 0; v = 2'b01;
    sel_n = 0; en_n = 0; rdy_n = 0; last_en = -1; done_at = -1; bad = 0; rdy_ok = 0;
    for (int k = 0; k < 20 && done_at < 0; k++) begin
      advance();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL write k=%0d: got %h want %h", k, dut_vec(), exp_vec());
      end
      if (p_sel_x) begin
        sel_n++;
        if (!p_write || p_addr !== 32'h0 || p_wdata !== 32'hFF00FF00) bad++;
      end
      if (p_enable) begin en_n++; last_en = k; end
      if (rq0_ready) begin rdy_n++; rdy_ok = p_sel_x && !p_enable; end
      if (rq0_done) done_at = k;
      req_update();
    end
    advance();
    checks++;
    if (sel_n != 5 || en_n != AC) begin
      errors++; $display("FAIL write_phases: sel %0d en %0d want sel 5 en %0d", sel_n, en_n, AC);
    end
    checks++;
    if (rdy_n != 1 || !rdy_ok) begin
      errors++; $display("FAIL write_ready: count %0d in_setup %b want 1 1", rdy_n, rdy_ok);
    end
    checks++;
    if (done_at < 0 || done_at != last_en + 1) begin
      errors++; $display("FAIL write_done: at %0d want %0d", done_at, last_en + 1);
    end
    checks++;
    if (bad != 0 || rq0_rdata !== 32'h0 || busy !== 1'b0) begin
      errors++; $display("FAIL write_cmd: bad %0d rdata %h busy %b want 0 0 0", bad, rq0_rdata, busy);
    end
  endtask

  task automatic test_single_read();
    logic [31:0] rd0;
    bit seen;
    rnd_cmd = 0; force_rd = 1; force_val = 32'hA5A50F0F;
    wr[1] = 0; addr[1] = 32'h100; wdata[1] = $urandom();
    want[0] = 0; want[1] = 1; v = 2'b10;
    rd0 = rq0_rdata; seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      advance();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL read k=%0d: got %h want %h", k, dut_vec(), exp_vec());
      end
      if (rq1_done) begin
        seen = 1;
        checks++;
        if (rq1_rdata !== 32'hA5A50F0F || rq0_rdata !== rd0) begin
          errors++; $display("FAIL read_data: rq1 %h rq0 %h want A5A50F0F %h", rq1_rdata, rq0_rdata, rd0);
        end
      end
      req_update();
    end
    advance();
    checks++;
    if (!seen || busy !== 1'b0) begin
      errors++; $display("FAIL read_done: seen %b busy %b want 1 0", seen, busy);
    end
    force_rd = 0;
  endtask

  task automatic test_back_to_back();
    bit grants[$];
    int last_done;
    rnd_cmd = 1; wr_only = 0;
    want[0] = 2; want[1] = 2; new_cmd(0); new_cmd(1); v = 2'b11;
    last_done = -1;
    for (int k = 0; k < 80 && (want[0] > 0 || want[1] > 0 || busy); k++) begin
      advance();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL b2b k=%0d: got %h want %h", k, dut_vec(), exp_vec());
      end
      if (rq0_ready || rq1_ready) begin
        grants.push_back(rq1_ready);
        if (last_done >= 0) begin
          checks++;
          if (k - last_done != 2) begin
            errors++; $display("FAIL b2b_gap: done-to-ready %0d want 2", k - last_done);
          end
        end
      end
      if (rq0_done || rq1_done) last_done = k;
      req_update();
    end
    checks++;
    if (grants.size() != 4) begin
      errors++; $display("FAIL b2b_count: got %0d want 4", grants.size());
    end
    for (int i = 0; i < grants.size(); i++) begin
      checks++;
      if (grants[i] != bit'(i % 2)) begin
        errors++; $display("FAIL b2b_order[%0d]: got %0d want %0d", i, grants[i], i % 2);
      end
    end
  endtask

  task automatic test_no_starvation();
    bit grants[$];
    bit raised;
    rnd_cmd = 1; wr_only = 0;
    want[0] = 4; want[1] = 0; new_cmd(0); v = 2'b01;
    raised = 0;
    for (int k = 0; k < 80 && (want[0] > 0 || want[1] > 0 || busy); k++) begin
      advance();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL starve k=%0d: got %h want %h", k, dut_vec(), exp_vec());
      end
      if (rq0_ready || rq1_ready) grants.push_back(rq1_ready);
      req_update();
      if (grants.size() == 1 && !raised) begin
        raised = 1; want[1] = 1; new_cmd(1); v[1] = 1'b1;
      end
    end
    checks++;
    if (grants.size() != 5 || grants[1] != 1'b1) begin
      errors++; $display("FAIL starve_order: count %0d second %0d want 5 1", grants.size(), grants.size() > 1 ? int'(grants[1]) : -1);
    end
  endtask

  task automatic test_reset_abort();
    int d0, d1;
    rnd_cmd = 0; wr_only = 0; force_rd = 0;
    wr[0] = 0; addr[0] = 32'h200; wdata[0] = 0;
    want[0] = 1; want[1] = 0; v = 2'b01;
    for (int k = 0; k < 20 && !(m_act && m_t == 2); k++) begin
      advance();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL abort_pre k=%0d: got %h want %h", k, dut_vec(), exp_vec());
      end
      req_update();
      if (rq0_ready) begin
        want[1] = 1; wr[1] = 0; addr[1] = 32'h300; wdata[1] = 0; v[1] = 1'b1;
      end
    end
    checks++;
    if (!(m_act && m_t == 2) || p_enable !== 1'b1 || p_sel_x !== 1'b1) begin
      errors++; $display("FAIL abort_setup: en %b sel %b want 1 1", p_enable, p_sel_x);
    end
    #2 p_resetn = 0;
    #1;
    checks++;
    if ({p_sel_x, p_enable, busy} !== 3'b000) begin
      errors++; $display("FAIL abort_async: sel/en/busy %b want 000", {p_sel_x, p_enable, busy});
    end
    for (int j = 0; j < 3; j++) begin
      advance();
      checks++;
      if (dut_vec() !== 136'h0) begin
        errors++; $display("FAIL abort_hold: got %h want 0", dut_vec());
      end
    end
    want[0] = 0;
    p_resetn = 1;
    d0 = 0; d1 = 0;
    for (int k = 0; k < 30 && (want[1] > 0 || busy); k++) begin
      advance();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL abort_post k=%0d: got %h want %h", k, dut_vec(), exp_vec());
      end
      d0 += int'(rq0_done); d1 += int'(rq1_done);
      req_update();
    end
    checks++;
    if (d0 != 0 || d1 != 1) begin
      errors++; $display("FAIL abort_serve: rq0 done %0d rq1 done %0d want 0 1", d0, d1);
    end
  endtask

  task automatic test_random();
    rnd_cmd = 1; wr_only = 0; force_rd = 0;
    want[0] = 0; want[1] = 0;
    for (int k = 0; k < 600; k++) begin
      advance();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL random k=%0d: got %h want %h", k, dut_vec(), exp_vec());
      end
      req_update();
      for (int i = 0; i < 2; i++) begin
        if (k < 560 && want[i] == 0 && $urandom_range(0, 5) == 0) begin
          want[i] = $urandom_range(1, 3); new_cmd(i); v[i] = 1'b1;
        end else if (v[i] && $urandom_range(0, 11) == 0) begin
          want[i] = 0; v[i] = 1'b0;
        end
      end
    end
    want[0] = 0; want[1] = 0; v = 2'b00;
    for (int k = 0; k < 20 && busy; k++) advance();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL random_drain: busy %b want 0", busy);
    end
  endtask

  initial begin
    addr[0] = 0; addr[1] = 0; wdata[0] = 0; wdata[1] = 0;
    want[0] = 0; want[1] = 0; force_val = 0;
    test_reset();
    test_single_write();
    test_single_read();
    test_back_to_back();
    test_no_starvation();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
